// File: rtl/usb_tx_bit_stuff_nrzi.sv
// Full-speed USB transmit bit stuffer with integrated NRZI encoder.
// Consumes one raw bit per clk12_i cycle over valid/ready. After MAX_ONES
// consecutive ones it inserts a zero on its own. All outputs are registered,
// so an input accepted in cycle n appears on raw_bit_o/line_o in cycle n+1.
module usb_tx_bit_stuff_nrzi #(
  parameter int MAX_ONES   = 6,
  parameter int NRZI_EN    = 1,
  parameter int IDLE_LEVEL = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk12_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             stuff_en_i,
  input  logic             data_valid_i,
  input  logic             data_i,
  output logic             data_ready_o,
  output logic             bit_valid_o,
  output logic             raw_bit_o,
  output logic             line_o,
  output logic             stuffing_o,
  output logic [CNT_W-1:0] stuff_count_o
);

  localparam int            RUN_W    = $clog2(MAX_ONES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_ONES);
  localparam logic          IDLE_LVL = (IDLE_LEVEL != 0);

  // Registered state
  logic [RUN_W-1:0] r_run;
  logic             r_bit_valid;
  logic             r_raw;
  logic             r_line;
  logic             r_stuffing;
  logic [CNT_W-1:0] r_stuff_cnt;

  // Next-state values
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_bit_valid_nxt;
  logic             w_raw_nxt;
  logic             w_line_nxt;
  logic             w_stuffing_nxt;
  logic [CNT_W-1:0] w_stuff_cnt_nxt;

  logic             w_stuff_pending;
  logic             w_accept;
  logic             w_emit;
  logic             w_emit_bit;

  // A full run owes a stuff zero; it pre-empts the input so it follows the run directly
  assign w_stuff_pending = stuff_en_i && (r_run == RUN_MAX);
  assign data_ready_o    = !clear_i && !w_stuff_pending;
  assign w_accept        = data_valid_i && data_ready_o;

  // Next-state: clear > stuff > accept > idle
  always_comb begin
    w_run_nxt       = r_run;
    w_bit_valid_nxt = 1'b0;
    w_raw_nxt       = r_raw;
    w_line_nxt      = r_line;
    w_stuffing_nxt  = 1'b0;
    w_stuff_cnt_nxt = r_stuff_cnt;
    w_emit          = 1'b0;
    w_emit_bit      = 1'b0;

    if (clear_i) begin
      w_run_nxt       = '0;
      w_line_nxt      = IDLE_LVL;
      w_stuff_cnt_nxt = '0;
    end else if (w_stuff_pending) begin
      w_emit         = 1'b1;
      w_emit_bit     = 1'b0;
      w_stuffing_nxt = 1'b1;
      w_run_nxt      = '0;
      // Statistic saturates rather than wrapping
      if (r_stuff_cnt != {CNT_W{1'b1}})
        w_stuff_cnt_nxt = r_stuff_cnt + 1'b1;
    end else if (w_accept) begin
      w_emit     = 1'b1;
      w_emit_bit = data_i;
      w_run_nxt  = (data_i && stuff_en_i) ? r_run + 1'b1 : '0;
    end else if (!stuff_en_i) begin
      // Idle gaps keep the run alive, but bypass always kills it
      w_run_nxt = '0;
    end

    if (w_emit) begin
      w_bit_valid_nxt = 1'b1;
      w_raw_nxt       = w_emit_bit;
      if (NRZI_EN != 0)
        w_line_nxt = w_emit_bit ? r_line : ~r_line;
      else
        w_line_nxt = w_emit_bit;
    end
  end

  // State register with asynchronous reset to idle line level
  always_ff @(posedge clk12_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run       <= '0;
      r_bit_valid <= 1'b0;
      r_raw       <= 1'b0;
      r_line      <= IDLE_LVL;
      r_stuffing  <= 1'b0;
      r_stuff_cnt <= '0;
    end else begin
      r_run       <= w_run_nxt;
      r_bit_valid <= w_bit_valid_nxt;
      r_raw       <= w_raw_nxt;
      r_line      <= w_line_nxt;
      r_stuffing  <= w_stuffing_nxt;
      r_stuff_cnt <= w_stuff_cnt_nxt;
    end
  end

  assign bit_valid_o   = r_bit_valid;
  assign raw_bit_o     = r_raw;
  assign line_o        = r_line;
  assign stuffing_o    = r_stuffing;
  assign stuff_count_o = r_stuff_cnt;

endmodule

// File: doc/usb_tx_bit_stuff_nrzi.md
Name: usb_tx_bit_stuff_nrzi

Overview:
Parametrised full-speed USB transmit bit stuffer with an integrated NRZI encoder. It sits between the TX serializer and the line driver and consumes one raw bit per clk12_i cycle through a valid/ready handshake. After MAX_ONES consecutive ones it inserts a zero on its own, and it also provides NRZI line coding, a stuffing bypass for EOP/SE0 phases, a synchronous clear, and a saturating stuff-bit statistic.

Parameters:
MAX_ONES, 6, run length of consecutive ones that triggers insertion of a stuff zero (valid range 1..15)
NRZI_EN, 1, 1 = line output NRZI-encoded; 0 = line output equals raw stuffed bit
IDLE_LEVEL, 1, line level after reset/clear (1 = J)
CNT_W, 8, width of saturating stuff-bit counter

Ports:
clk12_i  input  1  bit clock, one line bit per cycle
rst_ni  input  1  asynchronous active-low reset
clear_i  input  1  synchronous packet-start clear of run counter, line level and stuff count
stuff_en_i  input  1  1 = stuffing active; 0 = bypass (EOP, test)
data_valid_i  input  1  data_i holds a valid raw bit
data_i  input  1  raw bit
data_ready_o  output  1  bit is consumed this cycle when data_valid_i && data_ready_o
bit_valid_o  output  1  raw_bit_o/line_o carry a new bit this cycle
raw_bit_o  output  1  stuffed bit before NRZI
line_o  output  1  encoded line level
stuffing_o  output  1  current output bit is an inserted stuff bit
stuff_count_o  output  CNT_W  number of inserted stuff bits, saturating

Behaviour:
- Reset (rst_ni low, async): run counter=0, bit_valid_o=0, raw_bit_o=0, stuffing_o=0, line_o=IDLE_LEVEL, stuff_count_o=0.
- Run counter width $clog2(MAX_ONES+1). It counts consecutive accepted ones while stuff_en_i=1.
- stuff_pending = stuff_en_i && (counter == MAX_ONES).
- data_ready_o = !clear_i && !stuff_pending (combinational).
- Per cycle, priority is clear_i > stuff_pending > accept > idle:
  - clear_i: counter=0, line_o=IDLE_LEVEL, stuff_count_o=0, bit_valid_o=0, stuffing_o=0. No input is consumed.
  - stuff_pending: emit raw 0 with bit_valid_o=1 and stuffing_o=1, counter=0, stuff_count_o+1 (saturating at 2^CNT_W-1). This happens regardless of data_valid_i, because the stuff bit must immediately follow the run.
  - accept (valid && ready): emit data_i with bit_valid_o=1 and stuffing_o=0. Counter becomes counter+1 when data_i=1 and stuff_en_i=1, otherwise 0.
  - idle: bit_valid_o=0, stuffing_o=0. Counter, line_o and raw_bit_o hold.
- Latency: an input accepted in cycle n appears on raw_bit_o/line_o in cycle n+1. All outputs are registered.
- NRZI (NRZI_EN=1): line_o toggles when the emitted bit is 0 and holds when it is 1. It updates only when a bit is emitted. NRZI_EN=0: line_o equals the emitted raw bit.
- Valid gaps do not break a run. Ones separated by idle cycles still count toward MAX_ONES.
- stuff_en_i low: counter forced to 0 on the next edge and no insertion occurs. Deasserting it while stuff_pending=1 cancels the pending stuff bit.
- A run of exactly MAX_ONES ones followed by a 0 still gets a stuff bit before that 0. The counter resets only at the stuff bit or at a data 0.

Test Plan:
- MAX_ONES=6, IDLE=1, stream 1111111 continuously valid -> raw_bit_o 1,1,1,1,1,1,0,1. data_ready_o low exactly in the cycle after the 6th accept. line_o 1,1,1,1,1,1,0,0. stuff_count_o=1, stuffing_o high on the 7th output only.
- Stream 10110 with NRZI from J=1 -> line_o 1,0,0,0,1. No stuffing, counter never above 2.
- Six ones with 3 idle cycles between the 3rd and 4th -> stuff zero still inserted after the 6th one. bit_valid_o low during the gaps and line_o held.
- stuff_en_i=0, stream of 10 ones -> 10 consecutive output ones, data_ready_o constantly high, stuff_count_o unchanged.
- clear_i asserted together with data_valid_i after 4 ones -> input not consumed, line_o=1 next cycle, stuff_count_o=0. The following 6 ones need a fresh stuff bit only after the 6th.
- rst_ni pulsed low mid-run and mid-stuff (asynchronously, between edges) -> outputs reset immediately. CNT_W=2 with 5 stuff events -> stuff_count_o saturates at 3.
